// File: rtl/mips_trace_buffer.sv
// mips_trace_buffer: captures one {instr_num, flags, result} entry per retired
// instruction and queues it in a FIFO drained through a valid/ready port.
// The head entry lives in a dedicated output register (rd_data_q/rd_valid_q);
// the memory holds the entries queued behind it, so count = memory + head.
module mips_trace_buffer #(
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              capture_en,
  input  logic [5:0]        instr_num,
  input  logic [31:0]       result,
  input  logic              overflow,
  input  logic              equal,
  input  logic              carry,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [40:0]       rd_data,
  output logic [AW:0]       count,
  output logic              full,
  output logic [DROP_W-1:0] dropped
);

  typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  state_t             state_q;
  logic [5:0]         last_num_q;
  logic [40:0]        mem_q [DEPTH];
  logic [AW-1:0]      wptr_q, rptr_q;
  logic [AW:0]        count_q;
  logic               rd_valid_q;
  logic [40:0]        rd_data_q;
  logic [DROP_W-1:0]  dropped_q;

  logic [40:0]        entry_d;
  logic               push_req, pop, accept, load_head, from_mem, head_from_in, mem_wr;
  logic [AW:0]        mem_cnt;

  // Push/pop decisions and routing of the incoming entry (head register or memory)
  always_comb begin
    entry_d      = {instr_num, overflow, equal, carry, result};
    // Leaving IDLE always records the current instruction; afterwards only changes do.
    push_req     = capture_en && ((state_q == IDLE) || (instr_num != last_num_q));
    pop          = rd_valid_q && rd_ready;
    accept       = push_req && ((count_q != DEPTH_C) || pop);
    mem_cnt      = count_q - (AW+1)'(rd_valid_q);
    load_head    = !rd_valid_q || pop;
    from_mem     = load_head && (mem_cnt != '0);
    // With an empty queue behind the head, a new entry goes straight to the head.
    head_from_in = load_head && (mem_cnt == '0) && accept;
    mem_wr       = accept && !head_from_in;
  end

  // Capture FSM: IDLE -> ARM on the arming push, ARM -> RUN, any -> IDLE when disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_num_q <= '0;
    end else if (!capture_en) begin
      state_q    <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          state_q    <= ARM;
          last_num_q <= instr_num;
        end
        default: begin
          state_q <= RUN;
          if (instr_num != last_num_q) last_num_q <= instr_num;
        end
      endcase
    end
  end

  // Entry storage behind the head; contents are meaningless when not counted
  always_ff @(posedge clk) begin
    if (mem_wr) mem_q[wptr_q] <= entry_d;
  end

  // Pointers, occupancy, registered read port and saturating drop counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      dropped_q  <= '0;
    end else begin
      if (from_mem) begin
        rd_data_q  <= mem_q[rptr_q];
        rd_valid_q <= 1'b1;
        rptr_q     <= rptr_q + 1'b1;
      end else if (head_from_in) begin
        rd_data_q  <= entry_d;
        rd_valid_q <= 1'b1;
      end else if (load_head) begin
        rd_valid_q <= 1'b0;
      end
      if (mem_wr) wptr_q <= wptr_q + 1'b1;
      count_q <= count_q + (AW+1)'(accept) - (AW+1)'(pop);
      if (push_req && !accept && (dropped_q != {DROP_W{1'b1}}))
        dropped_q <= dropped_q + 1'b1;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign count    = count_q;
  assign full     = (count_q == DEPTH_C);
  assign dropped  = dropped_q;

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Directed bench for mips_trace_buffer: capture, drain order, full/drop
// behaviour, instr_num wrap, re-arm and asynchronous reset.
module tb_mips_trace_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        capture_en;
  logic [5:0]  instr_num;
  logic [31:0] result;
  logic        overflow, equal, carry;
  logic        rd_valid;
  logic        rd_ready;
  logic [40:0] rd_data;
  logic [4:0]  count;
  logic        full;
  logic [7:0]  dropped;

  int total = 0;
  int bad   = 0;

  mips_trace_buffer #(.DEPTH(16), .AW(4), .DROP_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .capture_en(capture_en), .instr_num(instr_num),
    .result(result), .overflow(overflow), .equal(equal), .carry(carry),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .count(count), .full(full), .dropped(dropped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [40:0] ent(input logic [5:0] n, input logic o, input logic e,
                                      input logic c, input logic [31:0] r);
    return {n, o, e, c, r};
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; capture_en = 1'b0; instr_num = '0; result = '0;
    overflow = 1'b0; equal = 1'b0; carry = 1'b0; rd_ready = 1'b0;
    tick(); tick();
    chk("rst_valid", rd_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_dropped", dropped, 0);
    chk("rst_data", rd_data, 0);
    rst_n = 1'b1;
    tick();

    // Arming capture and hold
    capture_en = 1'b1; instr_num = 6'd0; result = 32'h5;
    tick();
    chk("arm_valid", rd_valid, 1);
    chk("arm_data", rd_data, 41'h5);
    chk("arm_count", count, 1);
    tick(); tick();
    chk("hold_count", count, 1);

    // Three more instructions, then drain in order
    instr_num = 6'd1; result = 32'h10; tick();
    instr_num = 6'd2; result = 32'h20; carry = 1'b1; tick();
    instr_num = 6'd3; result = 32'h30; carry = 1'b0; tick();
    chk("four_count", count, 4);
    rd_ready = 1'b1;
    chk("drain0", rd_data, ent(6'd0, 0, 0, 0, 32'h5));   tick();
    chk("drain1", rd_data, ent(6'd1, 0, 0, 0, 32'h10));  tick();
    chk("drain2", rd_data, ent(6'd2, 0, 0, 1, 32'h20));  tick();
    chk("drain3", rd_data, ent(6'd3, 0, 0, 0, 32'h30));  tick();
    chk("drained_valid", rd_valid, 0);
    chk("drained_count", count, 0);
    rd_ready = 1'b0;

    // Overfill: 19 distinct instructions, 16 kept, 3 dropped
    for (int i = 0; i < 19; i++) begin
      instr_num = 6'(10 + i); result = 32'h100 + 32'(i); tick();
    end
    chk("ovf_full", full, 1);
    chk("ovf_count", count, 16);
    chk("ovf_dropped", dropped, 3);
    chk("ovf_head", rd_data, ent(6'd10, 0, 0, 0, 32'h100));

    // Full with simultaneous push and pop every cycle
    rd_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      instr_num = 6'(29 + k); result = 32'h113 + 32'(k);
      if (k < 16) chk("fullpp_head", rd_data, ent(6'(10 + k), 0, 0, 0, 32'h100 + 32'(k)));
      else        chk("fullpp_head", rd_data, ent(6'(13 + k), 0, 0, 0, 32'h103 + 32'(k)));
      tick();
      chk("fullpp_count", count, 16);
    end
    chk("fullpp_dropped", dropped, 3);
    rd_ready = 1'b0;

    // Wrap 62,63,0,1 then re-arm on instr 1
    capture_en = 1'b0; rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    capture_en = 1'b1; result = '0;
    instr_num = 6'd62; tick();
    instr_num = 6'd63; tick();
    instr_num = 6'd0;  tick();
    instr_num = 6'd1;  tick();
    chk("wrap_count", count, 4);
    capture_en = 1'b0; tick(); tick();
    chk("idle_count", count, 4);
    capture_en = 1'b1; tick();
    chk("rearm_count", count, 5);
    tick();
    chk("rearm_hold", count, 5);
    capture_en = 1'b0; rd_ready = 1'b1;
    chk("wrap_n0", rd_data[40:35], 6'd62); tick();
    chk("wrap_n1", rd_data[40:35], 6'd63); tick();
    chk("wrap_n2", rd_data[40:35], 6'd0);  tick();
    chk("wrap_n3", rd_data[40:35], 6'd1);  tick();
    chk("wrap_n4", rd_data[40:35], 6'd1);  tick();
    chk("wrap_empty", rd_valid, 0);
    rd_ready = 1'b0;

    // Asynchronous reset mid-drain with count=5, dropped=2
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    capture_en = 1'b1;
    for (int i = 0; i < 18; i++) begin
      instr_num = 6'(i); result = 32'(i); tick();
    end
    chk("pre_dropped", dropped, 2);
    capture_en = 1'b0; rd_ready = 1'b1;
    repeat (11) tick();
    rd_ready = 1'b0;
    chk("pre_count", count, 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_valid", rd_valid, 0);
    chk("arst_dropped", dropped, 0);
    chk("arst_full", full, 0);
    rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
